twos_decoder: RTL and testbench
===============================

# twos_decoder

Sequential two's-complement to sign-magnitude decoder; the inverse of the combinational two's-complement encoder on the lab top level. It accepts one WIDTH-bit signed word on a start strobe and processes it bit-serially, LSB first, using the copy-until-first-one-then-invert rule. After a fixed latency it presents the unsigned magnitude and a sign bit. The top level instantiates it with switches driving A and LEDs showing Y, Sign, Ovf, busy and done.

## Interface
- WIDTH, default 8: input word and magnitude width in bits; legal range is 2 or more.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled on a rising edge only in IDLE or DONE.
- A  in  WIDTH  two's-complement operand; captured on the accepting edge.
- Y  out  WIDTH  unsigned magnitude of the last completed operand.
- Sign  out  1  sign of the last completed operand; 1 means negative.
- Ovf  out  1  last operand was the most negative value, 1 followed by WIDTH-1 zeros.
- busy  out  1  high while a conversion is in progress (SHIFT state).
- done  out  1  one-cycle pulse when Y, Sign and Ovf update.

## Operation
- FSM states: IDLE, SHIFT, DONE. Encoding is free.
- IDLE, start=1: capture A into the shift register. Latch sign_r = A[WIDTH-1]. Clear bit counter, seen_one and the result register. Go to SHIFT.
- IDLE, start=0: hold.
- SHIFT, each edge: take b = shift register LSB.
  - Output bit = b XOR (sign_r AND seen_one), using seen_one before this bit.
  - Then seen_one |= b.
  - Shift the output bit into the result register from the MSB side, and shift the operand right.
  - Increment the counter.
- SHIFT, edge that processes bit WIDTH-1: load Y from the completed result, Sign from sign_r, and Ovf from (sign_r AND operand bits WIDTH-2..0 all zero). Go to DONE.
- Positive operands also take the full WIDTH cycles, so latency is data-independent.
- DONE: done=1 for exactly one cycle.
  - start=1 on the next edge: accepted as in IDLE (back-to-back); go to SHIFT.
  - Otherwise go to IDLE.
- start in SHIFT: ignored. No queueing, and the in-flight result is unaffected.
- Y, Sign and Ovf change only on the edge entering DONE. They hold between conversions.
- Arithmetic:
  - Y = |A| as unsigned WIDTH bits.
  - Most-negative input gives Y = 2^(WIDTH-1) (e.g. 0x80) with Sign=1 and Ovf=1. This is correct unsigned but not representable as a positive signed value.
  - A = 0 gives Y=0, Sign=0.

## Timing
- Reset, asynchronous on rst_n low:
  - State goes to IDLE.
  - Y=0, Sign=0, Ovf=0, busy=0, done=0.
  - Shift register, counter, seen_one and sign_r are cleared.
- Reset mid-conversion: the conversion is abandoned, no done pulse, and outputs return to reset values.
- Reset release: the first edge with rst_n high may accept start.
- Latency: start accepted at edge k.
  - busy=1 after edges k through k+WIDTH-1.
  - The edge k+WIDTH loads outputs; done=1 and busy=0 for the cycle after edge k+WIDTH.
  - With WIDTH=8: 8 edges from acceptance to outputs valid.
- Throughput: one word per WIDTH+1 edges with back-to-back start.
- busy and done are never high together. All outputs are registered, with no combinational path from inputs.

## Test plan
- Reset, then A=0xFB (-5), start pulse -> busy for 8 cycles; then done pulse, Y=0x05, Sign=1, Ovf=0.
- A=0x25, start -> after 8 edges Y=0x25, Sign=0, Ovf=0. Also A=0x00 -> Y=0x00, Sign=0.
- A=0x80, start -> Y=0x80, Sign=1, Ovf=1. Also A=0xFF -> Y=0x01, Sign=1, Ovf=0.
- Start held during SHIFT with A changed to 0x01 mid-run; original A=0x9C -> result Y=0x64, Sign=1, only one done pulse. Then start=1 in the DONE cycle with A=0x7F -> new conversion gives Y=0x7F, Sign=0 after 8 more edges.
- A=0xF0 started; rst_n pulsed low after the 4th shift edge -> all outputs 0 immediately, no done. After release, A=0x10 -> Y=0x10, Sign=0.
- Exhaustive sweep of all 256 values of A at WIDTH=8 -> Y, Sign and Ovf match the reference model |A|, A<0 and A==0x80; latency is constant at 8 edges.

Source files
------------

// File: rtl/twos_decoder_if.sv
// Handshake/data bundle between a requester and the two's-complement decoder.
interface twos_decoder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] Y;
    logic             Sign;
    logic             Ovf;
    logic             busy;
    logic             done;

    // Requester side: issues start/A, observes results and status.
    modport master (output start, A, input Y, Sign, Ovf, busy, done);
    // Decoder side.
    modport slave  (input start, A, output Y, Sign, Ovf, busy, done);
endinterface

// File: rtl/twos_decoder.sv
// Bit-serial two's-complement to sign-magnitude decoder.
// LSB-first "copy until the first one, then invert" rule; fixed WIDTH-edge
// latency regardless of operand value. All outputs are registered.
module twos_decoder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    twos_decoder_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_seen;
    logic             r_sign;
    logic [WIDTH-1:0] r_y;
    logic             r_sgn_o;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;

    logic             w_b;
    logic             w_obit;
    logic             w_last;

    // Current serial bit, its decoded value, and last-bit detect.
    // Inversion uses seen_one from before this bit, so the first one is copied.
    assign w_b    = r_shift[0];
    assign w_obit = w_b ^ (r_sign & r_seen);
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    // Control FSM with datapath and registered outputs.
    // Ovf: on the last bit, seen_one still covers only bits WIDTH-2..0, so
    // sign set with nothing seen means the most negative value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_seen  <= 1'b0;
            r_sign  <= 1'b0;
            r_y     <= '0;
            r_sgn_o <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_shift <= bus.A;
                        r_sign  <= bus.A[WIDTH-1];
                        r_cnt   <= '0;
                        r_seen  <= 1'b0;
                        r_res   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    r_shift <= r_shift >> 1;
                    r_res   <= {w_obit, r_res[WIDTH-1:1]};
                    r_seen  <= r_seen | w_b;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_y     <= {w_obit, r_res[WIDTH-1:1]};
                        r_sgn_o <= r_sign;
                        r_ovf   <= r_sign & ~r_seen;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.Y    = r_y;
    assign bus.Sign = r_sgn_o;
    assign bus.Ovf  = r_ovf;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule

// File: tb/tb_twos_decoder.sv
// Self-checking bench for twos_decoder (WIDTH=8): directed cases, reset
// abort, back-to-back start, exhaustive sweep and random operands.
module tb_twos_decoder;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    twos_decoder_if #(.WIDTH(W)) bus ();

    twos_decoder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Single comparison point.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: interpret the word as a signed integer, take |v|.
    function automatic void ref_model(input logic [W-1:0] a, output logic [W-1:0] y,
                                      output logic s, output logic o);
        int v;
        v = int'(a);
        if (v >= (1 << (W - 1))) v = v - (1 << W);
        s = (v < 0);
        y = W'((v < 0) ? -v : v);
        o = (v == -(1 << (W - 1)));
    endfunction

    // Called at the negedge right after the accepting edge; returns at the
    // negedge where done is seen (or the bound expires).
    task automatic wait_done(input logic [W-1:0] a);
        int         cyc;
        logic [W-1:0] ey, prev_y;
        logic       es, eo;
        ref_model(a, ey, es, eo);
        prev_y = bus.Y;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 40) begin
            chk("busy_in_shift", {31'd0, bus.busy}, 32'd1);
            chk("Y_hold_in_shift", {24'd0, bus.Y}, {24'd0, prev_y});
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, W);
        chk("done", {31'd0, bus.done}, 32'd1);
        chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
        chk("Y", {24'd0, bus.Y}, {24'd0, ey});
        chk("Sign", {31'd0, bus.Sign}, {31'd0, es});
        chk("Ovf", {31'd0, bus.Ovf}, {31'd0, eo});
    endtask

    // Full single conversion with a one-cycle start pulse.
    task automatic conv(input logic [W-1:0] a);
        logic [W-1:0] ey;
        logic es, eo;
        ref_model(a, ey, es, eo);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = W'($urandom);
        wait_done(a);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
        chk("Y_hold_after", {24'd0, bus.Y}, {24'd0, ey});
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.A     = '0;
        repeat (2) @(negedge clk);
        chk("rst_Y", {24'd0, bus.Y}, 32'd0);
        chk("rst_Sign", {31'd0, bus.Sign}, 32'd0);
        chk("rst_Ovf", {31'd0, bus.Ovf}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        rst_n = 1'b1;

        // Directed values.
        conv(8'hFB);
        chk("FB_Y", {24'd0, bus.Y}, 32'h05);
        conv(8'h25);
        conv(8'h00);
        conv(8'h80);
        chk("80_Ovf", {31'd0, bus.Ovf}, 32'd1);
        conv(8'hFF);

        // start held through SHIFT with A changed; then back-to-back in DONE.
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 8'h9C;
        @(negedge clk);
        bus.A     = 8'h01;
        wait_done(8'h9C);
        bus.A     = 8'h7F;
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_busy", {31'd0, bus.busy}, 32'd1);
        wait_done(8'h7F);
        @(negedge clk);
        chk("b2b_done_one_cycle", {31'd0, bus.done}, 32'd0);

        // Reset abort mid-conversion.
        conv(8'h25);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 8'hF0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_Y", {24'd0, bus.Y}, 32'd0);
        chk("abort_Sign", {31'd0, bus.Sign}, 32'd0);
        chk("abort_Ovf", {31'd0, bus.Ovf}, 32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", {31'd0, bus.done}, 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_rst_idle", {30'd0, bus.busy, bus.done}, 32'd0);
        end
        conv(8'h10);

        // Exhaustive sweep.
        for (int i = 0; i < 256; i++) conv(W'(i));

        // Random operands, alternating single and back-to-back.
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] a1, a2;
            a1 = W'($urandom);
            a2 = W'($urandom);
            @(negedge clk);
            bus.start = 1'b1;
            bus.A     = a1;
            @(negedge clk);
            bus.start = ($urandom_range(0, 1) == 1);
            bus.A     = W'($urandom);
            wait_done(a1);
            bus.start = 1'b1;
            bus.A     = a2;
            @(negedge clk);
            bus.start = 1'b0;
            wait_done(a2);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
